mem_write_ctrl: RTL and testbench
=================================

MEM_WRITE_CTRL -- requirements
Module: mem_write_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 store_req  input  1  single-cycle store request from CPU control; sampled only in IDLE.
REQ-005 store_type  input  2  00 SB, 01 SH, 10 SW, 11 reserved.
REQ-006 addr_in  input  32  byte address of the store.
REQ-007 data_in  input  32  rt register value, numeric (CPU) byte order.
REQ-008 waitrequest  input  1  memory stall; the transfer is accepted in a cycle where write=1 and waitrequest=0.
REQ-009 address  output  32  word-aligned address: {addr_in[31:2], 2'b00}.
REQ-010 write  output  1  memory write strobe.
REQ-011 writedata  output  32  lane-ordered store data.
REQ-012 byteenable  output  4  active lanes; bit k selects lane k (bits 8k+7:8k), which is byte offset k.
REQ-013 busy  output  1  high while a write is outstanding.
REQ-014 done  output  1  one-cycle pulse after the memory accepts the write.
REQ-015 misaligned  output  1  one-cycle pulse when a request is rejected.
REQ-016 stall_count  output  8  count of waitrequest cycles in the current or last write; saturates at 255.

Function
REQ-017 FSM states SHALL be IDLE and WRITE.
REQ-018 IDLE: a valid store_req at edge N SHALL register the address, writedata and byteenable outputs and enter WRITE.
REQ-019 write=1 and busy=1 SHALL be asserted from cycle N+1.
REQ-020 WRITE: address, writedata and byteenable SHALL be held constant while waitrequest=1.
REQ-021 WRITE: stall_count SHALL increment by 1 per waitrequest=1 cycle, saturating at 255.
REQ-022 WRITE: in a cycle with waitrequest=0, the transfer completes and the FSM SHALL return to IDLE.
REQ-023 After completion, the next cycle SHALL have write=0, busy=0 and done=1.
REQ-024 Minimum latency SHALL be: request at cycle N, write at N+1, done at N+2.
REQ-025 store_req SHALL be ignored while in WRITE; no queuing.
REQ-026 A new store_req SHALL be accepted in the same cycle that done=1.
REQ-027 stall_count SHALL clear to 0 on acceptance of each new request and otherwise hold its value in IDLE.
REQ-028 The byte order on writedata SHALL be the inverse of the instruction fetch path, which reverses bytes on read: the byte at offset 0 is the MSB.
REQ-029 SW: writedata={data_in[7:0],data_in[15:8],data_in[23:16],data_in[31:24]}; byteenable=1111.
REQ-030 SH at offset 0: byteenable=0011; lane0=data_in[15:8]; lane1=data_in[7:0].
REQ-031 SH at offset 2: byteenable=1100; lane2=data_in[15:8]; lane3=data_in[7:0].
REQ-032 SB at offset k: byteenable bit k only; lane k=data_in[7:0].
REQ-033 For SB and SH, lanes that are not enabled SHALL be driven to 0.
REQ-034 A request SHALL be rejected if any of these hold: SH with addr_in[0]=1, SW with addr_in[1:0]!=00, or store_type=11.
REQ-035 On a rejected request: no write is issued, misaligned=1 for one cycle at N+1, the FSM stays in IDLE, and the write outputs keep their previous values.
REQ-036 In IDLE, write SHALL be 0 and address, writedata and byteenable SHALL hold their last values.

Reset
REQ-037 While reset=1 at a clock edge, the FSM SHALL go to IDLE and every output SHALL be 0.
REQ-038 Reset SHALL take priority over all other inputs, including store_req in the same cycle.
REQ-039 Reset during WRITE SHALL abandon the transfer: write=0 in the next cycle, with no done and no misaligned pulse.

Verification
REQ-040 SW, addr 0x1004, data 0x11223344, waitrequest=0 -> at N+1 address=0x1004, writedata=0x44332211, byteenable=1111; at N+2 done=1, stall_count=0.
REQ-041 SB, addr 0x2003, data 0x000000AB -> byteenable=1000, writedata=0xAB000000.
REQ-042 SH, addr 0x2002, data 0x0000BEEF, waitrequest high 3 cycles -> byteenable=1100, writedata=0xEFBE0000, outputs stable 4 cycles, done 1 cycle after accept, stall_count=3.
REQ-043 SW, addr 0x1002 -> misaligned=1 at N+1; write stays 0; busy stays 0.
REQ-044 Request, then reset asserted on the 2nd stall cycle -> next cycle write=0, all outputs 0, no done; a following SW completes normally.
REQ-045 Back-to-back: second store_req in the done cycle is accepted -> write=1 in the next cycle; a store_req issued during WRITE is ignored.

Source files
------------

// File: rtl/mem_write_ctrl.sv
// Store-path memory write controller: formats CPU store data into byte lanes,
// issues one memory write and waits out waitrequest stalls.
module mem_write_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        store_req,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic        waitrequest,
  output logic [31:0] address,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic [7:0]  stall_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        done_q, done_d;
  logic        mis_q, mis_d;
  logic [7:0]  stall_q, stall_d;

  logic        reject;
  logic [31:0] lane_data;
  logic [3:0]  lane_be;

  // Byte offset 0 carries the most significant byte of the stored value.
  always_comb begin
    lane_data = 32'h0;
    lane_be   = 4'b0000;
    reject    = 1'b0;
    case (store_type)
      ST_SB: begin
        lane_data = {24'h0, data_in[7:0]} << {addr_in[1:0], 3'b000};
        lane_be   = 4'b0001 << addr_in[1:0];
      end
      ST_SH: begin
        reject = addr_in[0];
        if (addr_in[1]) begin
          lane_data = {data_in[7:0], data_in[15:8], 16'h0};
          lane_be   = 4'b1100;
        end else begin
          lane_data = {16'h0, data_in[7:0], data_in[15:8]};
          lane_be   = 4'b0011;
        end
      end
      ST_SW: begin
        reject    = (addr_in[1:0] != 2'b00);
        lane_data = {data_in[7:0], data_in[15:8], data_in[23:16], data_in[31:24]};
        lane_be   = 4'b1111;
      end
      default: reject = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    stall_d = stall_q;
    case (state_q)
      IDLE: begin
        if (store_req) begin
          if (reject) begin
            mis_d = 1'b1;
          end else begin
            state_d = WRITE;
            addr_d  = {addr_in[31:2], 2'b00};
            wdata_d = lane_data;
            be_d    = lane_be;
            stall_d = 8'd0;
          end
        end
      end
      WRITE: begin
        if (waitrequest) begin
          stall_d = (stall_q == 8'hFF) ? stall_q : stall_q + 8'd1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'b0000;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      stall_q <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      stall_q <= stall_d;
    end
  end

  assign address     = addr_q;
  assign writedata   = wdata_q;
  assign byteenable  = be_q;
  assign write       = (state_q == WRITE);
  assign busy        = (state_q == WRITE);
  assign done        = done_q;
  assign misaligned  = mis_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_mem_write_ctrl.sv
// Self-checking bench for mem_write_ctrl: directed cases followed by random
// stores compared against a byte-addressed big-endian store model.
module tb_mem_write_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        store_req;
  logic [1:0]  store_type;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic        waitrequest;
  logic [31:0] address;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        busy;
  logic        done;
  logic        misaligned;
  logic [7:0]  stall_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_addr  = 32'h0;
  logic [31:0] exp_wdata = 32'h0;
  logic [3:0]  exp_be    = 4'h0;
  int          exp_stall = 0;

  mem_write_ctrl dut (
    .clk(clk), .reset(reset), .store_req(store_req), .store_type(store_type),
    .addr_in(addr_in), .data_in(data_in), .waitrequest(waitrequest),
    .address(address), .write(write), .writedata(writedata),
    .byteenable(byteenable), .busy(busy), .done(done),
    .misaligned(misaligned), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Store of an s-byte value to address a: byte i of memory (a+i) holds the
  // i-th most significant byte of the value.
  function automatic int store_size(input logic [1:0] t);
    return (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : (t == 2'd2) ? 4 : 0;
  endfunction

  task automatic model(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                       output bit legal, output logic [31:0] wd, output logic [3:0] be);
    int s;
    int lane;
    s     = store_size(t);
    legal = (s != 0) && ((a % s) == 0);
    wd    = 32'h0;
    be    = 4'h0;
    if (legal) begin
      for (int i = 0; i < s; i++) begin
        lane = int'(a % 4) + i;
        wd[lane*8 +: 8] = 8'((d >> (8 * (s - 1 - i))) & 32'hFF);
        be[lane]        = 1'b1;
      end
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".address"}, address, exp_addr);
    chk({tag, ".writedata"}, writedata, exp_wdata);
    chk({tag, ".byteenable"}, 32'(byteenable), 32'(exp_be));
    chk({tag, ".stall_count"}, 32'(stall_count), 32'(exp_stall));
  endtask

  // Called at a negedge; returns at the negedge of the done (or post-reject) cycle.
  task automatic do_store(input string tag, input logic [1:0] t, input logic [31:0] a,
                          input logic [31:0] d, input int nstall, input bit poke);
    bit          legal;
    logic [31:0] wd;
    logic [3:0]  be;
    model(t, a, d, legal, wd, be);
    store_req   = 1'b1;
    store_type  = t;
    addr_in     = a;
    data_in     = d;
    waitrequest = 1'b0;
    @(negedge clk);
    store_req = 1'b0;
    if (!legal) begin
      chk({tag, ".misaligned"}, 32'(misaligned), 32'd1);
      chk({tag, ".write"}, 32'(write), 32'd0);
      chk({tag, ".busy"}, 32'(busy), 32'd0);
      chk({tag, ".done"}, 32'(done), 32'd0);
      chk_outputs({tag, ".hold"});
      @(negedge clk);
      chk({tag, ".mis_pulse"}, 32'(misaligned), 32'd0);
    end else begin
      exp_addr  = {a[31:2], 2'b00};
      exp_wdata = wd;
      exp_be    = be;
      exp_stall = 0;
      chk({tag, ".write"}, 32'(write), 32'd1);
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".done"}, 32'(done), 32'd0);
      chk_outputs(tag);
      for (int i = 0; i < nstall; i++) begin
        waitrequest = 1'b1;
        if (poke) begin
          store_req  = 1'b1;
          store_type = 2'(~t);
          addr_in    = $urandom;
          data_in    = $urandom;
        end
        @(negedge clk);
        store_req = 1'b0;
        if (exp_stall < 255) exp_stall++;
        chk({tag, ".stall_write"}, 32'(write), 32'd1);
        chk({tag, ".stall_mis"}, 32'(misaligned), 32'd0);
        chk_outputs({tag, ".stall"});
      end
      waitrequest = 1'b0;
      @(negedge clk);
      chk({tag, ".end_write"}, 32'(write), 32'd0);
      chk({tag, ".end_busy"}, 32'(busy), 32'd0);
      chk({tag, ".end_done"}, 32'(done), 32'd1);
      chk_outputs({tag, ".end"});
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".write"}, 32'(write), 32'd0);
    chk({tag, ".mis"}, 32'(misaligned), 32'd0);
    chk_outputs(tag);
  endtask

  initial begin
    logic [1:0]  rt;
    logic [31:0] ra;
    reset       = 1'b1;
    store_req   = 1'b1;
    store_type  = 2'b10;
    addr_in     = 32'h1000;
    data_in     = 32'hDEADBEEF;
    waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.write", 32'(write), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.mis", 32'(misaligned), 32'd0);
    chk_outputs("reset");
    store_req = 1'b0;
    reset     = 1'b0;
    @(negedge clk);

    do_store("sw_1004", 2'b10, 32'h1004, 32'h11223344, 0, 1'b0);
    chk("sw_1004.wd_const", writedata, 32'h44332211);
    idle_check("idle1");
    do_store("sb_2003", 2'b00, 32'h2003, 32'h000000AB, 1, 1'b0);
    chk("sb_2003.wd_const", writedata, 32'hAB000000);
    do_store("sh_2002", 2'b01, 32'h2002, 32'h0000BEEF, 3, 1'b1);
    chk("sh_2002.wd_const", writedata, 32'hEFBE0000);
    chk("sh_2002.stall_const", 32'(stall_count), 32'd3);
    idle_check("idle2");
    do_store("sw_1002", 2'b10, 32'h1002, 32'h55667788, 0, 1'b0);
    do_store("sh_odd", 2'b01, 32'h3001, 32'h1234, 0, 1'b0);
    do_store("rsv", 2'b11, 32'h3000, 32'h1234, 0, 1'b0);

    // Reset in the second stall cycle abandons the write.
    store_req = 1'b1; store_type = 2'b10; addr_in = 32'h4000; data_in = 32'hCAFEF00D;
    @(negedge clk);
    store_req   = 1'b0;
    waitrequest = 1'b1;
    chk("rst_mid.write", 32'(write), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    waitrequest = 1'b0;
    exp_addr = 32'h0; exp_wdata = 32'h0; exp_be = 4'h0; exp_stall = 0;
    chk("rst_mid.write0", 32'(write), 32'd0);
    chk("rst_mid.busy0", 32'(busy), 32'd0);
    chk("rst_mid.done0", 32'(done), 32'd0);
    chk_outputs("rst_mid");
    idle_check("rst_after");
    do_store("sw_after_rst", 2'b10, 32'h5008, 32'h01020304, 2, 1'b0);

    // Back-to-back: new requests issued in the done cycle.
    do_store("b2b_a", 2'b01, 32'h6000, 32'h0000A1B2, 0, 1'b0);
    do_store("b2b_b", 2'b00, 32'h6001, 32'h000000C3, 0, 1'b0);
    do_store("b2b_c", 2'b10, 32'h600C, 32'h89ABCDEF, 1, 1'b1);

    do_store("sat", 2'b10, 32'h7000, 32'h0BADF00D, 260, 1'b0);
    chk("sat.final", 32'(stall_count), 32'd255);
    idle_check("sat_hold");

    for (int n = 0; n < 40; n++) begin
      rt = 2'($urandom_range(0, 3));
      ra = $urandom;
      do_store($sformatf("rnd%0d", n), rt, ra, $urandom, int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d.idle", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
